// File: rtl/fmap_pingpong_reader_if.sv
// Pixel stream from the ping-pong reader to the squeeze 1x1 stage.
// o_data/o_last are meaningful only while o_valid is high.
interface fmap_pingpong_reader_if #(
  parameter int DATA_W = 1024
);
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_last;
  logic              i_ready;

  modport master (
    output o_data,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/fmap_pingpong_reader.sv
// Read side of the maxpool->squeeze ping-pong feature-map buffer.
// Walks each full bank in turn and streams pixel words downstream.
module fmap_pingpong_reader #(
  parameter int DATA_W     = 1024,
  parameter int ADDR_W     = 32,
  parameter int FRAME_SIZE = 3025
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_frame_done,
  input  logic              wr_bank_sel,
  output logic [1:0]        bank_free,
  output logic              mem_rden,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  fmap_pingpong_reader_if.master s,
  output logic              o_frame_done,
  output logic              o_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(FRAME_SIZE - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_full;
  logic              r_cur;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_infl;
  logic              r_infl_last;
  logic              r_fdone;
  logic              r_ovr;

  logic [DATA_W-1:0] r_dat [2];
  logic [1:0]        r_lst;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;

  logic              w_pop;
  logic [2:0]        w_credit;
  logic              w_issue;
  logic              w_at_last;
  logic              w_rel;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  assign s.o_valid = (r_cnt != 2'd0);
  assign s.o_data  = r_dat[r_rp];
  assign s.o_last  = s.o_valid & r_lst[r_rp];

  assign w_pop = s.o_valid & s.i_ready;

  // Occupancy after this cycle, counting the read still in flight
  assign w_credit = {1'b0, r_cnt}
                  + {2'b0, r_infl}
                  - {2'b0, w_pop};

  assign w_issue   = (r_state == READ)
                   & (w_credit < 3'd2);
  assign w_at_last = (r_rd_ptr == LAST_A);
  assign w_rel     = (r_state == DRAIN)
                   & w_pop & s.o_last;

  assign w_set = wr_frame_done
               ? (2'b01 << wr_bank_sel) : 2'b00;
  assign w_clr = w_rel
               ? (2'b01 << r_cur) : 2'b00;

  assign mem_rden     = w_issue;
  assign mem_bank     = r_cur;
  assign mem_addr     = r_rd_ptr;
  assign bank_free    = ~r_full;
  assign o_frame_done = r_fdone;
  assign o_overrun    = r_ovr;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_full[r_cur])
          w_state_nxt = READ;
      end
      READ: begin
        if (w_issue && w_at_last)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_rel)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_full      <= 2'b00;
      r_cur       <= 1'b0;
      r_rd_ptr    <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_fdone     <= 1'b0;
      r_ovr       <= 1'b0;
      r_lst       <= 2'b00;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      // A new frame on a still-full bank wins over the release
      r_full  <= (r_full & ~w_clr) | w_set;
      r_ovr   <= r_ovr
               | (wr_frame_done
                  & r_full[wr_bank_sel]);
      r_fdone <= w_rel;
      if (w_rel)
        r_cur <= ~r_cur;
      if (r_state == IDLE)
        r_rd_ptr <= '0;
      else if (w_issue)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_infl      <= w_issue;
      r_infl_last <= w_at_last;
      if (r_infl) begin
        r_lst[r_wp] <= r_infl_last;
        r_wp        <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_cnt <= r_cnt
             + {1'b0, r_infl}
             - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (r_infl)
      r_dat[r_wp] <= mem_data;
  end

endmodule

// File: tb/tb_fmap_pingpong_reader.sv
// Bench for fmap_pingpong_reader: bank memory model plus
// a frame-order reference built from the filled bank contents.
module tb_fmap_pingpong_reader;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int F  = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic          wr_bank_sel = 1'b0;
  logic [1:0]    bank_free;
  logic          mem_rden;
  logic          mem_bank;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          o_frame_done;
  logic          o_overrun;

  fmap_pingpong_reader_if #(.DATA_W(DW)) sif ();

  fmap_pingpong_reader #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .FRAME_SIZE(F)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_frame_done(wr_frame_done),
    .wr_bank_sel  (wr_bank_sel),
    .bank_free    (bank_free),
    .mem_rden     (mem_rden),
    .mem_bank     (mem_bank),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .s            (sif),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bank [2][F];
  logic [DW-1:0] obs_d [$];
  logic          obs_l [$];
  int n_chk  = 0;
  int n_pass = 0;

  // One-cycle read latency; garbage outside a read keeps stale captures visible
  always @(posedge clk) begin
    if (mem_rden && mem_addr < AW'(F))
      mem_data <= bank[mem_bank][mem_addr[3:0]];
    else
      mem_data <= DW'($urandom);
  end

  task automatic fill(input int b, input int base,
                      input bit rnd);
    for (int a = 0; a < F; a++)
      bank[b][a] = rnd ? DW'($urandom) : DW'(base + a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    wr_frame_done = 1'b0;
    sif.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse(input bit b);
    @(negedge clk);
    wr_frame_done = 1'b1;
    wr_bank_sel = b;
    @(negedge clk);
    wr_frame_done = 1'b0;
  endtask

  // mode 0: ready high, 1: 1,0,0,1 pattern, 2: random
  task automatic collect(input int n, input int mode,
                         input int tail, input int budget,
                         output int hold_err, output int fd,
                         output bit tmo);
    logic [DW-1:0] pd;
    bit pstall;
    int t;
    obs_d.delete();
    obs_l.delete();
    hold_err = 0;
    fd = 0;
    tmo = 1'b1;
    pstall = 1'b0;
    pd = '0;
    t = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mode == 0)
        sif.i_ready = 1'b1;
      else if (mode == 1)
        sif.i_ready = (c % 4 == 0) || (c % 4 == 3);
      else
        sif.i_ready = 1'($urandom_range(0, 1));
      if (pstall && (!sif.o_valid || sif.o_data !== pd))
        hold_err++;
      if (o_frame_done)
        fd++;
      pstall = sif.o_valid && !sif.i_ready;
      pd = sif.o_data;
      if (sif.o_valid && sif.i_ready) begin
        obs_d.push_back(sif.o_data);
        obs_l.push_back(sif.o_last);
      end
      if (obs_d.size() >= n) begin
        if (t >= tail) begin
          tmo = 1'b0;
          break;
        end
        t++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if (bank_free !== 2'b11)
      $display("FAIL reset_bank_free got %b want 11",
               bank_free);
    else n_pass++;
    n_chk++;
    if ({mem_rden, mem_bank} !== 2'b00 || mem_addr !== '0)
      $display("FAIL reset_mem got %b%b %0h want 0 0 0",
               mem_rden, mem_bank, mem_addr);
    else n_pass++;
    n_chk++;
    if ({sif.o_valid, sif.o_last, o_frame_done,
         o_overrun} !== 4'b0000)
      $display("FAIL reset_out got %b%b%b%b want 0000",
               sif.o_valid, sif.o_last, o_frame_done,
               o_overrun);
    else n_pass++;
  endtask

  task automatic test_single();
    int first_k, last_k, fd_k, idx, err;
    logic bf0;
    do_reset();
    fill(0, 0, 1'b0);
    sif.i_ready = 1'b1;
    first_k = -1; last_k = -1; fd_k = -1;
    idx = 0; err = 0; bf0 = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b1;
    wr_bank_sel = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) wr_frame_done = 1'b0;
      if (k == 5) bf0 = bank_free[0];
      if (o_frame_done && fd_k < 0) fd_k = k;
      if (sif.o_valid) begin
        if (first_k < 0) first_k = k;
        if (sif.o_data !== DW'(idx) ||
            sif.o_last !== (idx == F - 1) ||
            k != 4 + idx) err++;
        if (sif.o_last) last_k = k;
        idx++;
      end
    end
    n_chk++;
    if (first_k != 4)
      $display("FAIL single_latency got %0d want 4",
               first_k);
    else n_pass++;
    n_chk++;
    if (err != 0 || idx != F)
      $display("FAIL single_stream got %0d words %0d bad want %0d 0",
               idx, err, F);
    else n_pass++;
    n_chk++;
    if (last_k != 4 + F - 1 || fd_k != 4 + F)
      $display("FAIL single_end got last %0d fd %0d want %0d %0d",
               last_k, fd_k, 4 + F - 1, 4 + F);
    else n_pass++;
    n_chk++;
    if (bf0 !== 1'b0 || bank_free !== 2'b11)
      $display("FAIL single_free got %b %b want 0 11",
               bf0, bank_free);
    else n_pass++;
  endtask

  task automatic test_stall();
    int he, fd, err;
    bit tmo;
    do_reset();
    fill(0, 0, 1'b1);
    pulse(1'b0);
    collect(F, 1, 3, 200, he, fd, tmo);
    err = 0;
    for (int i = 0; i < obs_d.size(); i++)
      if (i >= F || obs_d[i] !== bank[0][i] ||
          obs_l[i] !== (i == F - 1)) err++;
    n_chk++;
    if (tmo || err != 0 || obs_d.size() != F)
      $display("FAIL stall_stream got %0d words %0d bad tmo %0d want %0d 0 0",
               obs_d.size(), err, tmo, F);
    else n_pass++;
    n_chk++;
    if (he != 0 || fd != 1)
      $display("FAIL stall_hold got hold_err %0d fd %0d want 0 1",
               he, fd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int he, fd, err;
    bit tmo;
    do_reset();
    fill(0, 'h100, 1'b0);
    fill(1, 'h200, 1'b0);
    @(negedge clk);
    wr_frame_done = 1'b1;
    wr_bank_sel = 1'b0;
    @(negedge clk);
    wr_bank_sel = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b0;
    collect(2 * F, 2, 3, 400, he, fd, tmo);
    err = 0;
    for (int i = 0; i < obs_d.size(); i++)
      if (i >= 2 * F || obs_d[i] !== bank[i / F][i % F] ||
          obs_l[i] !== (i % F == F - 1)) err++;
    n_chk++;
    if (tmo || err != 0 || obs_d.size() != 2 * F)
      $display("FAIL b2b_stream got %0d words %0d bad tmo %0d want %0d 0 0",
               obs_d.size(), err, tmo, 2 * F);
    else n_pass++;
    n_chk++;
    if (fd != 2 || he != 0)
      $display("FAIL b2b_done got fd %0d hold_err %0d want 2 0",
               fd, he);
    else n_pass++;
    n_chk++;
    if (bank_free !== 2'b11 || o_overrun !== 1'b0)
      $display("FAIL b2b_free got %b ovr %b want 11 0",
               bank_free, o_overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int he, fd, err, extra;
    bit tmo;
    do_reset();
    fill(0, 0, 1'b1);
    @(negedge clk);
    wr_frame_done = 1'b1;
    wr_bank_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_frame_done = 1'b0;
    n_chk++;
    if (o_overrun !== 1'b1)
      $display("FAIL overrun_flag got %b want 1", o_overrun);
    else n_pass++;
    collect(F, 0, 3, 200, he, fd, tmo);
    err = 0;
    for (int i = 0; i < obs_d.size(); i++)
      if (i >= F || obs_d[i] !== bank[0][i]) err++;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sif.o_valid) extra++;
    end
    n_chk++;
    if (tmo || err != 0 || fd != 1 || extra != 0)
      $display("FAIL overrun_stream got bad %0d fd %0d extra %0d tmo %0d want 0 1 0 0",
               err, fd, extra, tmo);
    else n_pass++;
    n_chk++;
    if (o_overrun !== 1'b1 || bank_free !== 2'b11)
      $display("FAIL overrun_after got ovr %b free %b want 1 11",
               o_overrun, bank_free);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int he, fd, err;
    bit tmo;
    // Leave the sticky flag set so the reset must clear it
    n_chk++;
    if (o_overrun !== 1'b1)
      $display("FAIL midrst_pre got ovr %b want 1", o_overrun);
    else n_pass++;
    fill(0, 0, 1'b1);
    pulse(1'b0);
    collect(4, 0, 0, 100, he, fd, tmo);
    sif.i_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({sif.o_valid, o_overrun, mem_rden,
         o_frame_done} !== 4'b0000 || bank_free !== 2'b11)
      $display("FAIL midrst_out got v%b o%b r%b d%b f%b want 0 0 0 0 11",
               sif.o_valid, o_overrun, mem_rden,
               o_frame_done, bank_free);
    else n_pass++;
    rst = 1'b1;
    fill(0, 0, 1'b1);
    pulse(1'b0);
    collect(F, 0, 3, 200, he, fd, tmo);
    err = 0;
    for (int i = 0; i < obs_d.size(); i++)
      if (i >= F || obs_d[i] !== bank[0][i] ||
          obs_l[i] !== (i == F - 1)) err++;
    n_chk++;
    if (tmo || err != 0 || fd != 1)
      $display("FAIL midrst_frame got bad %0d fd %0d tmo %0d want 0 1 0",
               err, fd, tmo);
    else n_pass++;
  endtask

  task automatic test_no_ready();
    int he, fd, err, reads;
    bit tmo;
    do_reset();
    fill(0, 0, 1'b1);
    pulse(1'b0);
    reads = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rden) reads++;
    end
    n_chk++;
    if (reads != 2)
      $display("FAIL noready_reads got %0d want 2", reads);
    else n_pass++;
    n_chk++;
    if (sif.o_valid !== 1'b1 || sif.o_data !== bank[0][0])
      $display("FAIL noready_head got v%b %0h want 1 %0h",
               sif.o_valid, sif.o_data, bank[0][0]);
    else n_pass++;
    collect(F, 0, 3, 200, he, fd, tmo);
    err = 0;
    for (int i = 0; i < obs_d.size(); i++)
      if (i >= F || obs_d[i] !== bank[0][i]) err++;
    n_chk++;
    if (tmo || err != 0 || obs_d.size() != F || fd != 1)
      $display("FAIL noready_stream got %0d words %0d bad fd %0d want %0d 0 1",
               obs_d.size(), err, fd, F);
    else n_pass++;
  endtask

  initial begin
    sif.i_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    test_no_ready();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
